// File: rtl/datapath_param.sv
// datapath_param: register file, B-operand shifter, ALU, result register C and {Z,N,V} flags.
// Define DATAPATH_MUL_EN to add an iterative shift-add multiplier on ALUop 100.
module datapath_param #(
    parameter  int W    = 16,
    parameter  int NREG = 8,
    parameter  int PCW  = 8,
    localparam int RW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           write,
    input  logic [RW-1:0]  writenum,
    input  logic [RW-1:0]  readnum,
    input  logic [1:0]     vsel,
    input  logic [W-1:0]   mdata,
    input  logic [W-1:0]   sximm8,
    input  logic [W-1:0]   sximm5,
    input  logic [PCW-1:0] PC,
    input  logic           loada,
    input  logic           loadb,
    input  logic           loadc,
    input  logic           loads,
    input  logic           asel,
    input  logic           bsel,
    input  logic [1:0]     shift,
    input  logic [2:0]     ALUop,
    output logic [W-1:0]   C,
    output logic [2:0]     status_out,
    output logic           busy,
    output logic           done
);
    logic [W-1:0] r_regs [NREG];
    logic [W-1:0] r_a, r_b, r_c;
    logic [2:0]   r_status;

    logic [W-1:0] w_wdata, w_rd, w_shifted, w_ain, w_bin;
    logic [W-1:0] w_sum, w_diff, w_result;
    logic         w_ovf;

    // Multiplier hooks; tied off when the multiplier is not built.
    logic         w_busy, w_mul_start, w_mul_last, w_mul_flags_en, w_mul_ovf;
    logic [W-1:0] w_mul_res;

    always_comb begin
        w_wdata = mdata;
        case (vsel)
            2'b00:   w_wdata = mdata;
            2'b01:   w_wdata = sximm8;
            2'b10:   w_wdata = W'(PC);
            default: w_wdata = r_c;
        endcase
    end

    // Combinational read: a same-cycle write to readnum is seen only next cycle.
    assign w_rd = r_regs[readnum];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (write) begin
            r_regs[writenum] <= w_wdata;
        end
    end

    always_comb begin
        w_shifted = r_b;
        case (shift)
            2'b00:   w_shifted = r_b;
            2'b01:   w_shifted = {r_b[W-2:0], 1'b0};
            2'b10:   w_shifted = {1'b0, r_b[W-1:1]};
            default: w_shifted = {r_b[W-1], r_b[W-1:1]};
        endcase
    end

    assign w_ain = asel ? '0 : r_a;
    assign w_bin = bsel ? sximm5 : w_shifted;

    always_comb begin
        w_sum    = w_ain + w_bin;
        w_diff   = w_ain - w_bin;
        w_result = '0;
        w_ovf    = 1'b0;
        case (ALUop)
            3'b000: begin
                w_result = w_sum;
                w_ovf    = (w_ain[W-1] == w_bin[W-1]) && (w_sum[W-1] != w_ain[W-1]);
            end
            3'b001: begin
                w_result = w_diff;
                w_ovf    = (w_ain[W-1] != w_bin[W-1]) && (w_diff[W-1] != w_ain[W-1]);
            end
            3'b010:  w_result = w_ain & w_bin;
            3'b011:  w_result = ~w_bin;
            default: w_result = '0;
        endcase
    end

`ifdef DATAPATH_MUL_EN
    localparam int CW = $clog2(W) + 1;

    logic           r_busy, r_done, r_mul_loads;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_acc, r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] w_acc_next;

    assign w_mul_start = (ALUop == 3'b100) && loadc && !r_busy;
    assign w_mul_last  = r_busy && (r_cnt == CW'(W - 1));
    assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);

    // One multiplier bit per busy cycle; the final partial sum is written straight into C.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mul_loads <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
        end else begin
            r_done <= w_mul_last;
            if (w_mul_start) begin
                r_busy      <= 1'b1;
                r_cnt       <= '0;
                r_acc       <= '0;
                r_mcand     <= {{W{1'b0}}, w_ain};
                r_mplier    <= w_bin;
                r_mul_loads <= loads;
            end else if (r_busy) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (w_mul_last) r_busy <= 1'b0;
            end
        end
    end

    assign w_busy         = r_busy;
    assign w_mul_res      = w_acc_next[W-1:0];
    assign w_mul_ovf      = |w_acc_next[2*W-1:W];
    assign w_mul_flags_en = r_mul_loads;
    assign busy           = r_busy;
    assign done           = r_done;
`else
    assign w_busy         = 1'b0;
    assign w_mul_start    = 1'b0;
    assign w_mul_last     = 1'b0;
    assign w_mul_res      = '0;
    assign w_mul_ovf      = 1'b0;
    assign w_mul_flags_en = 1'b0;
    assign busy           = 1'b0;
    assign done           = 1'b0;
`endif

    // While a multiply runs, operand/result loads are ignored and C/flags hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
        end else if (w_busy) begin
            if (w_mul_last) begin
                r_c <= w_mul_res;
                if (w_mul_flags_en) r_status <= {~|w_mul_res, w_mul_res[W-1], w_mul_ovf};
            end
        end else begin
            if (loada) r_a <= w_rd;
            if (loadb) r_b <= w_rd;
            if (loadc && !w_mul_start) r_c <= w_result;
            if (loads && !w_mul_start) r_status <= {~|w_result, w_result[W-1], w_ovf};
        end
    end

    assign C          = r_c;
    assign status_out = r_status;
endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param (W=16, NREG=8); expectations queued at drive time, checked after the edge.
module tb_datapath_param;
    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int PCW  = 8;
    localparam int RW   = 3;

    logic           clk = 1'b0;
    logic           reset, write, loada, loadb, loadc, loads, asel, bsel;
    logic [RW-1:0]  writenum, readnum;
    logic [1:0]     vsel, shift;
    logic [W-1:0]   mdata, sximm8, sximm5;
    logic [PCW-1:0] PC;
    logic [2:0]     ALUop;
    logic [W-1:0]   C;
    logic [2:0]     status_out;
    logic           busy, done;

    always #5 clk = ~clk;

    datapath_param #(.W(W), .NREG(NREG), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .write(write), .writenum(writenum), .readnum(readnum),
        .vsel(vsel), .mdata(mdata), .sximm8(sximm8), .sximm5(sximm5), .PC(PC),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
        .shift(shift), .ALUop(ALUop), .C(C), .status_out(status_out), .busy(busy), .done(done)
    );

    typedef struct {
        string        tag;
        int           kind;   // 0 C, 1 status, 2 busy, 3 done
        logic [W-1:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [W-1:0] obs(input int kind);
        case (kind)
            0:       return C;
            1:       return W'(status_out);
            2:       return W'(busy);
            default: return W'(done);
        endcase
    endfunction

    function automatic void push(input string tag, input int kind, input logic [W-1:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = v;
        sb.push_back(e);
    endfunction

    task automatic check_all();
        while (sb.size() > 0) begin
            exp_t         e;
            logic [W-1:0] got;
            e   = sb.pop_front();
            got = obs(e.kind);
            n_cmp++;
            assert (got === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, got, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        write = 1'b0; writenum = '0; readnum = '0; vsel = 2'b00;
        mdata = '0; sximm8 = '0; sximm5 = '0; PC = '0;
        loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
        asel = 1'b0; bsel = 1'b0; shift = 2'b00; ALUop = 3'b000;
    endtask

    task automatic wr(input logic [RW-1:0] n, input logic [1:0] vs, input logic [W-1:0] d);
        write = 1'b1; writenum = n; vsel = vs; mdata = d; sximm8 = d; PC = d[PCW-1:0];
        cyc();
        idle();
    endtask

    task automatic ld(input logic a, input logic b, input logic [RW-1:0] n);
        readnum = n; loada = a; loadb = b;
        cyc();
        idle();
    endtask

    task automatic alu(input logic [2:0] op, input logic [1:0] sh, input logic as, input logic bs,
                       input logic ls, input logic [W-1:0] imm5);
        ALUop = op; shift = sh; asel = as; bsel = bs; loads = ls; sximm5 = imm5; loadc = 1'b1;
        cyc();
        idle();
    endtask

    // Route R[n] through B into C with A forced to zero.
    task automatic readback(input logic [RW-1:0] n, input logic [W-1:0] v, input string tag);
        ld(1'b0, 1'b1, n);
        push(tag, 0, v);
        alu(3'b000, 2'b00, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        push("rst_c", 0, '0); push("rst_st", 1, '0); push("rst_busy", 2, '0); push("rst_done", 3, '0);
        cyc();
        reset = 1'b0;

        // R0=7, R1=2 via sximm8; C = 2 + (7<<1)
        wr(3'd0, 2'b01, 16'd7);
        wr(3'd1, 2'b01, 16'd2);
        ld(1'b0, 1'b1, 3'd0);
        ld(1'b1, 1'b0, 3'd1);
        push("add_shl", 0, 16'd16);
        alu(3'b000, 2'b01, 1'b0, 1'b0, 1'b0, '0);
        wr(3'd2, 2'b11, 16'h0000);
        readback(3'd2, 16'd16, "wb_c_r2");

        // Write and read R3 in the same cycle: B gets the old value
        write = 1'b1; writenum = 3'd3; vsel = 2'b00; mdata = 16'd5; readnum = 3'd3; loadb = 1'b1;
        cyc();
        idle();
        push("rw_same_old", 0, 16'd0);
        alu(3'b000, 2'b00, 1'b1, 1'b0, 1'b0, '0);
        readback(3'd3, 16'd5, "rw_next_new");

        // Signed overflow on add, zero on sub
        wr(3'd4, 2'b00, 16'h7FFF);
        wr(3'd5, 2'b00, 16'h0001);
        ld(1'b1, 1'b0, 3'd4);
        ld(1'b0, 1'b1, 3'd5);
        push("add_ovf_c", 0, 16'h8000); push("add_ovf_st", 1, W'(3'b011));
        alu(3'b000, 2'b00, 1'b0, 1'b0, 1'b1, '0);
        wr(3'd6, 2'b00, 16'd5);
        ld(1'b1, 1'b1, 3'd6);
        push("sub_zero_c", 0, 16'd0); push("sub_zero_st", 1, W'(3'b100));
        alu(3'b001, 2'b00, 1'b0, 1'b0, 1'b1, '0);
        push("and_c", 0, 16'd5); push("and_st", 1, W'(3'b000));
        alu(3'b010, 2'b00, 1'b0, 1'b0, 1'b1, '0);
        push("not_c", 0, 16'hFFFA); push("not_st", 1, W'(3'b010));
        alu(3'b011, 2'b00, 1'b0, 1'b0, 1'b1, '0);
        push("add_imm5_c", 0, 16'd2);
        alu(3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFD);
        push("sub_imm5_c", 0, 16'd8);
        alu(3'b001, 2'b00, 1'b0, 1'b1, 1'b0, 16'hFFFD);

        // 0x8000 - 1 overflows negative-to-positive
        wr(3'd7, 2'b00, 16'h8000);
        ld(1'b1, 1'b0, 3'd7);
        ld(1'b0, 1'b1, 3'd5);
        push("sub_ovf_c", 0, 16'h7FFF); push("sub_ovf_st", 1, W'(3'b001));
        alu(3'b001, 2'b00, 1'b0, 1'b0, 1'b1, '0);

        // PC zero-extended on writeback
        wr(3'd7, 2'b10, 16'h12AB);
        readback(3'd7, 16'h00AB, "wb_pc");

        // Shifter edge cases on an all-ones B
        wr(3'd7, 2'b00, 16'hFFFF);
        ld(1'b0, 1'b1, 3'd7);
        push("shift_asr", 0, 16'hFFFF);
        alu(3'b000, 2'b11, 1'b1, 1'b0, 1'b0, '0);
        push("shift_lsr", 0, 16'h7FFF);
        alu(3'b000, 2'b10, 1'b1, 1'b0, 1'b0, '0);
        push("shift_lsl", 0, 16'hFFFE);
        alu(3'b000, 2'b01, 1'b1, 1'b0, 1'b0, '0);

        // Reserved ALUop yields zero result and V=0
        push("op101_c", 0, 16'd0); push("op101_st", 1, W'(3'b100));
        alu(3'b101, 2'b00, 1'b0, 1'b0, 1'b1, '0);

        // A=B=300, C=600 as a known prior value
        wr(3'd0, 2'b00, 16'd300);
        ld(1'b1, 1'b1, 3'd0);
        push("pre_mul_c", 0, 16'h0258);
        alu(3'b000, 2'b00, 1'b0, 1'b0, 1'b0, '0);

`ifdef DATAPATH_MUL_EN
        ALUop = 3'b100; loadc = 1'b1; loads = 1'b1;
        push("mul_start_busy", 2, 16'd1); push("mul_start_c", 0, 16'h0258);
        cyc();
        // Attempted loads during busy must be ignored
        ALUop = 3'b000; loadc = 1'b1; loads = 1'b1; loada = 1'b1; readnum = 3'd1;
        for (int k = 1; k < W; k++) begin
            push($sformatf("mul_busy%0d", k), 2, 16'd1);
            push($sformatf("mul_hold_c%0d", k), 0, 16'h0258);
            push($sformatf("mul_hold_st%0d", k), 1, W'(3'b100));
            push($sformatf("mul_nodone%0d", k), 3, 16'd0);
            cyc();
        end
        push("mul_end_busy", 2, 16'd0); push("mul_end_c", 0, 16'h5F90);
        push("mul_end_st", 1, W'(3'b001)); push("mul_done", 3, 16'd1);
        cyc();
        idle();
        push("mul_done_once", 3, 16'd0); push("mul_after_c", 0, 16'h5F90);
        cyc();
        push("mul_a_kept", 0, 16'd300);
        alu(3'b000, 2'b00, 1'b0, 1'b1, 1'b0, '0);

        // Abort a multiply with reset at busy cycle 5
        ALUop = 3'b100; loadc = 1'b1;
        push("mul2_busy", 2, 16'd1);
        cyc();
        idle();
        for (int k = 1; k < 5; k++) begin
            push($sformatf("mul2_busy%0d", k), 2, 16'd1);
            cyc();
        end
        reset = 1'b1;
        push("abort_busy", 2, 16'd0); push("abort_c", 0, 16'd0);
        push("abort_st", 1, 16'd0); push("abort_done", 3, 16'd0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            push($sformatf("abort_nodone%0d", k), 3, 16'd0);
            push($sformatf("abort_c%0d", k), 0, 16'd0);
            cyc();
        end
        for (int i = 0; i < NREG; i++) readback(RW'(i), '0, $sformatf("abort_r%0d", i));
`else
        push("mul_off_c", 0, 16'd0); push("mul_off_st", 1, W'(3'b100));
        push("mul_off_busy", 2, 16'd0); push("mul_off_done", 3, 16'd0);
        alu(3'b100, 2'b00, 1'b0, 1'b0, 1'b1, '0);
        for (int k = 0; k < 4; k++) begin
            push($sformatf("mul_off_busy%0d", k), 2, 16'd0);
            push($sformatf("mul_off_done%0d", k), 3, 16'd0);
            cyc();
        end
`endif

        // Reset wins over same-cycle write and loads
        wr(3'd1, 2'b00, 16'h1234);
        ld(1'b1, 1'b1, 3'd1);
        write = 1'b1; writenum = 3'd1; mdata = 16'hAAAA; loada = 1'b1; loadc = 1'b1; loads = 1'b1;
        reset = 1'b1;
        push("rst2_c", 0, '0); push("rst2_st", 1, '0); push("rst2_busy", 2, '0); push("rst2_done", 3, '0);
        cyc();
        reset = 1'b0;
        idle();
        for (int i = 0; i < NREG; i++) readback(RW'(i), '0, $sformatf("rst2_r%0d", i));
        push("rst2_a", 0, '0);
        alu(3'b000, 2'b00, 1'b0, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/datapath_param.md
DATAPATH_PARAM -- requirements
Module: datapath_param

Interface
REQ-001 Parameter W, 16, data width of registers, ALU and C.
REQ-002 Parameter NREG, 8, register-file depth (power of two, >=2); RW = $clog2(NREG).
REQ-003 Parameter PCW, 8, PC input width (PCW <= W).
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Ports write / writenum / readnum  input  1 / RW / RW  register-file write enable, write index, read index.
REQ-007 Port vsel  input  2  writeback source select.
REQ-008 Ports mdata / sximm8 / sximm5  input  W each  memory data, 8-bit immediate sign-extended, 5-bit immediate sign-extended.
REQ-009 Port PC  input  PCW  program counter for writeback.
REQ-010 Ports loada / loadb / loadc / loads / asel / bsel  input  1 each  register loads and operand selects.
REQ-011 Ports shift / ALUop  input  2 / 3  shifter op and ALU op.
REQ-012 Ports C / status_out  output  W / 3  result register; flags {Z,N,V} as [2:0].
REQ-013 Ports busy / done  output  1 / 1  multiply in progress; one-cycle completion pulse.

Function
REQ-014 Writeback data: vsel 00 mdata, 01 sximm8, 10 zero-extended PC, 11 C.
REQ-015 Register file: write at rising edge when write=1; read data_out = R[readnum], combinational; same-index same-cycle write/read returns the old value, new value next cycle.
REQ-016 loada=1 captures data_out into A; loadb=1 captures data_out into B; simultaneous loads both capture.
REQ-017 Shifter on B: 00 pass, 01 left by 1 (LSB 0), 10 logical right by 1, 11 arithmetic right by 1.
REQ-018 Operands: Ain = asel ? 0 : A; Bin = bsel ? sximm5 : shifted B.
REQ-019 ALUop: 000 Ain+Bin, 001 Ain-Bin, 010 Ain&Bin, 011 ~Bin, all mod 2^W, single cycle; loadc=1 captures result into C.
REQ-020 loads=1 captures flags: Z = result==0, N = result[W-1], V = signed overflow for add/sub, 0 for AND/NOT.
REQ-021 ALUop 100 (MUL), loadc=1, busy=0: capture Ain and Bin and loads, busy=1 next cycle; iterative shift-add, one bit per cycle.
REQ-022 MUL latency: start edge plus W edges; C = low W bits of unsigned product at edge W; busy falls at the same edge; done=1 the cycle after only.
REQ-023 MUL flags, updated only if loads was high at start: Z/N of low W bits; V=1 if upper W bits of 2W product nonzero.
REQ-024 While busy: loada, loadb, loadc, loads ignored; register-file writes proceed; C and status_out hold prior values.
REQ-025 ALUop 101..111: result 0, V=0, single cycle.

Reset
REQ-026 reset=1 at rising edge: A, B, C, all NREG registers, status_out, busy, done, multiply counter to 0; aborts in-flight MUL with no writeback; reset overrides all same-cycle loads/writes.

Configuration
REQ-027 Macro DATAPATH_MUL_EN defined: REQ-021..024 apply.
REQ-028 Macro DATAPATH_MUL_EN undefined: ALUop 100 treated as REQ-025; busy and done tied 0; no multiply hardware.

Verification
REQ-029 W=16: write R0=7 (vsel 01), R1=2; loadb R0, loada R1; shift 01, ALUop 000, loadc -> C=16, R2 writeback via vsel 11 reads 16.
REQ-030 A=0x7FFF, B=1, ALUop 000, loads -> C=0x8000, status {Z,N,V}=011; A=5, B=5, ALUop 001 -> C=0, status 100.
REQ-031 MUL enabled, A=300, B=300, loads -> busy high 16 cycles, C=0x5F90 at edge 16, V=1, done pulses once; loadc during busy ignored.
REQ-032 Reset asserted at busy cycle 5 of MUL -> busy=0, done never pulses, C=0, all registers read 0.
REQ-033 W=32, NREG=16: write R15=0xFFFF_FFFF, shift 11 -> C=0xFFFF_FFFF; shift 10 -> C=0x7FFF_FFFF.
REQ-034 MUL disabled build: ALUop 100 with loadc -> C=0 next cycle, busy and done stay 0.
